// File: rtl/mbscore_vic.sv
// mbscore_vic: vectored interrupt controller with level/edge capture, masking, fixed priority
// and in-service tracking. Define MBSCORE_VIC_NEST_EN to allow higher-priority nesting.
module mbscore_vic #(
    parameter int NUM_IRQ = 8,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE = ADDR_WIDTH'(32'h0000_0400),
    parameter int VEC_STRIDE_LOG2 = 4,
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  int_en_n,
    input  logic                  stop,
    input  logic                  eret,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [NUM_IRQ-1:0]    cfg_wdata,
    output logic [NUM_IRQ-1:0]    cfg_rdata,
    output logic                  int_jump,
    output logic                  setINTR,
    output logic [ADDR_WIDTH-1:0] int_addr,
    output logic [IDW-1:0]        active_id,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | nothing in service, waiting for an eligible request at a boundary
    // ISSUE   | one-cycle jump pulse, winner frozen in r_win
    // SERVICE | at least one channel active, waiting for eret
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SERVICE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_IRQ-1:0]    r_irq_q, r_pend, r_mask, r_edge, r_active;
    logic [IDW-1:0]        r_win;
    logic [ADDR_WIDTH-1:0] r_int_addr;

    logic [NUM_IRQ-1:0]    w_elig, w_pend_set, w_pend_clr, w_win_oh, w_ret_oh, w_act_set, w_ret_clr;
    logic [IDW-1:0]        w_win;
    logic [ADDR_WIDTH-1:0] w_vec;
    logic                  w_go, w_take, w_issue;

    function automatic logic [IDW-1:0] f_lsb(input logic [NUM_IRQ-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    assign w_elig     = r_pend & r_mask;
    assign w_win      = f_lsb(w_elig);
    assign w_go       = (|w_elig) & stop & ~int_en_n;
    assign w_vec      = VEC_BASE + (ADDR_WIDTH'(w_win) << VEC_STRIDE_LOG2);
    assign w_issue    = (r_state == ST_ISSUE);
    assign w_pend_set = (r_edge & irq & ~r_irq_q) | (~r_edge & irq);
    assign w_ret_oh   = r_active & (-r_active);
    assign w_ret_clr  = eret ? w_ret_oh : '0;
    assign w_act_set  = w_issue ? w_win_oh : '0;
    assign w_pend_clr = (w_issue ? w_win_oh : '0)
                      | ((cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0);

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_win_oh[i] = (r_win == IDW'(i));
        end
    end

`ifdef MBSCORE_VIC_NEST_EN
    logic [NUM_IRQ-1:0] w_act_left;
    assign w_act_left = r_active & ~w_ret_oh;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        int_jump    = 1'b0;
        setINTR     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_ISSUE;
                    w_take      = 1'b1;
                end
            end
            ST_ISSUE: begin
                int_jump    = 1'b1;
                setINTR     = 1'b1;
                w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
`ifdef MBSCORE_VIC_NEST_EN
                // a retirement takes the cycle; preemption is re-evaluated on the next one
                if (eret) begin
                    if (w_act_left == '0) w_state_nxt = ST_IDLE;
                end else if (w_go && (w_win < active_id)) begin
                    w_state_nxt = ST_ISSUE;
                    w_take      = 1'b1;
                end
`else
                if (eret) w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q    <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_active   <= '0;
            r_win      <= '0;
            r_int_addr <= VEC_BASE;
        end else begin
            r_irq_q  <= irq;
            r_pend   <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_active <= (r_active & ~w_ret_clr) | w_act_set;
            if (cfg_we && cfg_addr == 2'd0) r_mask <= cfg_wdata;
            if (cfg_we && cfg_addr == 2'd1) r_edge <= cfg_wdata;
            if (w_take) begin
                r_win      <= w_win;
                r_int_addr <= w_vec;
            end
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = r_mask;
            2'd1:    cfg_rdata = r_edge;
            2'd2:    cfg_rdata = r_pend;
            default: cfg_rdata = r_active;
        endcase
    end

    assign int_addr  = r_int_addr;
    assign active_id = f_lsb(r_active);
    assign busy      = |r_active;

endmodule

// File: tb/tb_mbscore_vic.sv
// Self-checking bench for mbscore_vic: directed test-plan steps plus randomized traffic
// compared against a per-cycle behavioural model of pending/active bookkeeping.
module tb_mbscore_vic;
`ifdef MBSCORE_VIC_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk, rst_n, int_en_n, stop, eret, cfg_we;
    logic [7:0]  irq, cfg_wdata, cfg_rdata;
    logic [1:0]  cfg_addr;
    logic        int_jump, setINTR, busy;
    logic [31:0] int_addr;
    logic [2:0]  active_id;

    int n_cmp = 0;
    int n_err = 0;

    bit [7:0]    m_pend, m_mask, m_edge, m_active, m_irqq;
    bit          m_jump;
    int          m_win;
    logic [31:0] m_addr;
    int          jumps;

    mbscore_vic dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .int_en_n(int_en_n), .stop(stop), .eret(eret),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_jump(int_jump), .setINTR(setINTR), .int_addr(int_addr),
        .active_id(active_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lsb8(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 0; m_active = 0; m_irqq = 0;
        m_jump = 0; m_win = 0; m_addr = 32'h400;
    endtask

    // one rising edge worth of the controller's rules, evaluated on pre-edge values
    task automatic model_edge();
        bit [7:0] elig, nxt_pend, nxt_act;
        bit       go, setb, clrb;
        int       w;
        elig = m_pend & m_mask;
        w    = lsb8(elig);
        go   = 0;
        if (!m_jump && elig != 0 && stop && !int_en_n) begin
            if (m_active == 0) go = 1;
            else if (NEST && !eret && w < lsb8(m_active)) go = 1;
        end
        for (int i = 0; i < 8; i++) begin
            setb = m_edge[i] ? (irq[i] && !m_irqq[i]) : irq[i];
            clrb = (m_jump && i == m_win) || (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]);
            nxt_pend[i] = setb ? 1'b1 : (clrb ? 1'b0 : m_pend[i]);
        end
        nxt_act = m_active;
        if (eret && m_active != 0) nxt_act[lsb8(m_active)] = 1'b0;
        if (m_jump) nxt_act[m_win] = 1'b1;
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
        if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata;
        m_irqq   = irq;
        m_pend   = nxt_pend;
        m_active = nxt_act;
        if (go) begin
            m_win  = w;
            m_addr = 32'h400 + 32'(w) * 16;
        end
        m_jump = go;
    endtask

    task automatic check_all();
        logic [7:0] exp_rd;
        case (cfg_addr)
            2'd0:    exp_rd = m_mask;
            2'd1:    exp_rd = m_edge;
            2'd2:    exp_rd = m_pend;
            default: exp_rd = m_active;
        endcase
        chk("int_jump", 32'(int_jump), 32'(m_jump));
        chk("setINTR", 32'(setINTR), 32'(m_jump));
        chk("int_addr", int_addr, m_addr);
        chk("active_id", 32'(active_id), 32'(lsb8(m_active)));
        chk("busy", 32'(busy), 32'(m_active != 0));
        chk("cfg_rdata", 32'(cfg_rdata), 32'(exp_rd));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (int_jump) jumps++;
    endtask

    task automatic cfg_wr(logic [1:0] a, logic [7:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 0; cfg_wdata = 0;
    endtask

    task automatic pulse_eret();
        eret = 1;
        step();
        eret = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        irq = 0; int_en_n = 1; stop = 0; eret = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        jumps = 0;
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk("rst_cfg", 32'(cfg_rdata), 32'h0);
        end
        chk("rst_addr", int_addr, 32'h400);
        chk("rst_jump", 32'(int_jump), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // single level request on channel 3
        cfg_wr(2'd0, 8'hFF);
        cfg_wr(2'd1, 8'h00);
        stop = 1; int_en_n = 0; cfg_addr = 2'd3;
        irq = 8'h08;
        step();
        irq = 8'h00;
        step();
        chk("tp1_jump", 32'(int_jump), 32'h1);
        chk("tp1_set", 32'(setINTR), 32'h1);
        chk("tp1_addr", int_addr, 32'h430);
        step();
        chk("tp1_pulse", 32'(int_jump), 32'h0);
        chk("tp1_active", 32'(cfg_rdata), 32'h08);
        chk("tp1_id", 32'(active_id), 32'h3);
        pulse_eret();
        chk("tp1_idle", 32'(busy), 32'h0);

        // two simultaneous requests: priority then the loser after eret
        irq = 8'h24;
        step();
        irq = 8'h00;
        step();
        chk("tp2_first", int_addr, 32'h420);
        step();
        step();
        chk("tp2_wait", 32'(int_jump), 32'h0);
        pulse_eret();
        step();
        chk("tp2_second", int_addr, 32'h450);
        chk("tp2_jump", 32'(int_jump), 32'h1);
        step();
        pulse_eret();

        // edge mode, long high level, masking and W1C
        cfg_wr(2'd1, 8'h02);
        jumps = 0;
        irq = 8'h02;
        repeat (10) step();
        chk("tp3_once", 32'(jumps), 32'h1);
        pulse_eret();
        cfg_wr(2'd0, 8'hFD);
        irq = 8'h00;
        step();
        jumps = 0;
        irq = 8'h02;
        cfg_addr = 2'd2;
        repeat (4) step();
        chk("tp3_masked_pend", 32'(cfg_rdata), 32'h02);
        chk("tp3_masked_nojump", 32'(jumps), 32'h0);
        cfg_wr(2'd2, 8'h02);
        cfg_addr = 2'd2;
        #1;
        chk("tp3_w1c", 32'(cfg_rdata), 32'h00);
        irq = 8'h00;
        cfg_wr(2'd0, 8'hFF);
        cfg_wr(2'd1, 8'h00);

        // gating by stop and int_en_n
        jumps = 0;
        stop = 0; int_en_n = 0;
        irq = 8'h40;
        step();
        irq = 8'h00;
        step();
        stop = 1; int_en_n = 1;
        repeat (2) step();
        chk("tp4_gated", 32'(jumps), 32'h0);
        int_en_n = 0;
        step();
        chk("tp4_release", 32'(int_jump), 32'h1);
        chk("tp4_addr", int_addr, 32'h460);
        step();
        pulse_eret();

        // reset in the middle of ISSUE
        irq = 8'h04;
        step();
        irq = 8'h00;
        step();
        chk("tp5_pre", 32'(int_jump), 32'h1);
        rst_n = 0;
        #1;
        chk("tp5_jump", 32'(int_jump), 32'h0);
        chk("tp5_set", 32'(setINTR), 32'h0);
        chk("tp5_addr", int_addr, 32'h400);
        chk("tp5_busy", 32'(busy), 32'h0);
        cfg_addr = 2'd2;
        #1;
        chk("tp5_pend", 32'(cfg_rdata), 32'h0);
        rst_n = 1;
        do_reset();

`ifdef MBSCORE_VIC_NEST_EN
        cfg_wr(2'd0, 8'hFF);
        cfg_addr = 2'd3;
        irq = 8'h10;
        step();
        irq = 8'h00;
        repeat (2) step();
        chk("nest_first", 32'(cfg_rdata), 32'h10);
        irq = 8'h01;
        step();
        irq = 8'h00;
        step();
        chk("nest_jump", 32'(int_jump), 32'h1);
        chk("nest_addr", int_addr, 32'h400);
        step();
        chk("nest_both", 32'(cfg_rdata), 32'h11);
        pulse_eret();
        chk("nest_ret1", 32'(cfg_rdata), 32'h10);
        pulse_eret();
        chk("nest_ret2", 32'(busy), 32'h0);
        do_reset();
`endif

        // randomized traffic against the model
        cfg_wr(2'd0, 8'hFF);
        for (int n = 0; n < 400; n++) begin
            irq      = 8'($urandom & $urandom & $urandom);
            stop     = ($urandom_range(0, 3) != 0);
            int_en_n = ($urandom_range(0, 7) == 0);
            eret     = ($urandom_range(0, 5) == 0);
            cfg_we   = ($urandom_range(0, 11) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = 8'($urandom);
            if (cfg_addr == 2'd0) cfg_wdata = cfg_wdata | 8'hC3;
            step();
        end
        irq = 0; eret = 0; cfg_we = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mbscore_vic.md
# mbscore_vic

Parametrised vectored interrupt controller for the MBScore SoC. It replaces the fixed-width interrupt controller in the CPU top. It latches up to `NUM_IRQ` request lines as level- or edge-sensitive, applies per-channel masking and fixed priority, and issues one vectored jump to the core at an instruction boundary. It tracks the in-service channel(s) until the core signals return-from-interrupt, and exposes a small configuration port for mask, mode, pending and active state.

## Interface
Parameters:
- `NUM_IRQ`, default 8: number of request channels (1–32); channel 0 has the highest priority.
- `ADDR_WIDTH`, default 32: width of `int_addr`.
- `VEC_BASE`, default 32'h0000_0400: address of vector 0.
- `VEC_STRIDE_LOG2`, default 4: vector spacing of 2^n bytes.

Ports:
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `irq  in  NUM_IRQ`: request lines, synchronous to `clk`.
- `int_en_n  in  1`: core global interrupt disable; 1 = disabled.
- `stop  in  1`: core is at an instruction boundary and can accept a jump.
- `eret  in  1`: one-cycle pulse; handler returned.
- `cfg_we  in  1`: configuration write strobe.
- `cfg_addr  in  2`: register select: 0 MASK, 1 EDGE, 2 PENDING, 3 ACTIVE.
- `cfg_wdata  in  NUM_IRQ`: write data.
- `cfg_rdata  out  NUM_IRQ`: read data, combinational on `cfg_addr`.
- `int_jump  out  1`: one-cycle pulse; core loads PC from `int_addr`.
- `setINTR  out  1`: one-cycle pulse coincident with `int_jump`; core sets `int_en_n`.
- `int_addr  out  ADDR_WIDTH`: vector of the last issued channel.
- `active_id  out  $clog2(NUM_IRQ)` (minimum 1): highest-priority in-service channel.
- `busy  out  1`: at least one channel is in service.

## Operation
- `irq_q` registers `irq` every cycle.
- Pending set rule:
  - EDGE[i]=1: `pending[i]` sets on `irq[i] & ~irq_q[i]`.
  - EDGE[i]=0: `pending[i]` sets whenever `irq[i]`=1.
- Pending clear sources: issue of channel i, or a cfg write to PENDING with bit i=1 (W1C). Set wins over clear in the same cycle.
- Masked channels (MASK[i]=0) still latch pending but are not eligible.
- `eligible = pending & MASK`. The winner is the lowest eligible index.
- FSM states and transitions:
  - IDLE → ISSUE: when `eligible`≠0, `stop`=1 and `int_en_n`=0.
  - ISSUE (lasts exactly one cycle): `int_jump`=`setINTR`=1; `int_addr` is registered to `VEC_BASE + (winner << VEC_STRIDE_LOG2)`; `pending[winner]` clears; `active[winner]` sets → SERVICE.
  - SERVICE → IDLE: on `eret` (non-nesting build). `eret` clears the lowest set bit of ACTIVE.
- The winner is frozen at the ISSUE entry edge. A higher-priority request arriving during ISSUE waits.
- Configuration registers:
  - MASK and EDGE: read/write.
  - PENDING: read returns pending; write is W1C.
  - ACTIVE: read-only; writes are ignored.
- `eret` in IDLE with ACTIVE=0 is ignored.
- `active_id` = index of the lowest set ACTIVE bit, 0 when none. `busy` = |ACTIVE.

## Timing
- Reset values: `irq_q`, pending, MASK, EDGE and ACTIVE = 0; state IDLE; `int_jump`=`setINTR`=0; `int_addr`=`VEC_BASE`; `active_id`=0; `busy`=0; `cfg_rdata` reflects the reset registers.
- Latency: `irq` sampled at edge k → pending visible after edge k → `int_jump` high in the cycle after edge k+1, provided the gating conditions hold during cycle k..k+1.
- `int_jump` never exceeds one cycle and never repeats without a new transition through ISSUE.
- Reset asserted mid-ISSUE or mid-SERVICE immediately drops `int_jump` and `setINTR` and returns to reset values; no deferred jump.
- A cfg write and an `irq` event on the same bit in the same cycle: the pending set wins.
- `eret` and an ISSUE-eligible request in the same cycle: ACTIVE clears this cycle; the next ISSUE may start the following cycle.

## Configuration
- `MBSCORE_VIC_NEST_EN`: when defined, SERVICE → ISSUE is permitted if the winner index < `active_id`, `stop`=1 and `int_en_n`=0. ACTIVE then holds multiple bits, and each `eret` retires the highest-priority active channel. SERVICE → IDLE occurs only when ACTIVE becomes 0.
- Without the macro, at most one ACTIVE bit is ever set, and new requests remain pending until `eret`.

## Test plan
- Reset, then MASK=0xFF, EDGE=0x00, `irq[3]`=1, `stop`=1, `int_en_n`=0 → `int_jump`/`setINTR` one-cycle pulse two edges after the sample, `int_addr`=0x430, ACTIVE=0x08, `active_id`=3.
- `irq[5]` and `irq[2]` asserted together, both unmasked → ISSUE picks 2 (`int_addr`=0x420); after `eret`, 5 issues (`int_addr`=0x450).
- EDGE[1]=1, `irq[1]` held high for 10 cycles → single pending/issue; MASK[1]=0 → pending=0x02 and no jump; W1C 0x02 → pending=0.
- `int_en_n`=1 or `stop`=0 with a pending request → no `int_jump`; deassert the gate → jump on the following cycle.
- `rst_n` pulsed low during ISSUE → `int_jump` drops the same cycle; all registers are at reset values and `int_addr`=0x400.
- `MBSCORE_VIC_NEST_EN` defined: channel 4 in service, `irq[0]` asserted → second jump to 0x400, ACTIVE=0x11; `eret` → ACTIVE=0x10; `eret` → idle.
